// File: rtl/vram_wb_dp.sv
// rtl/vram_wb_dp.sv - dual-port video RAM: Wishbone CPU port, VGA scan port, posted-write buffer
// Optional byte-lane writes are enabled by defining VRAM_WB_DP_BYTE_SEL_EN.
module vram_wb_dp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 1200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] sel_i,
    input  logic [31:0]         adr_i,
    input  logic [DATA_W-1:0]   dat_i,
    output logic [DATA_W-1:0]   dat_o,
    output logic                ack_o,
    input  logic [ADDR_W-1:0]   vga_addr,
    output logic [DATA_W-1:0]   vga_dout,
    output logic                pend_o
);
    localparam int NB  = DATA_W / 8;
    localparam int OFS = $clog2(NB);

    typedef enum logic {IDLE, ACK}   ack_state_t;
    typedef enum logic {EMPTY, FULL} buf_state_t;

    ack_state_t ack_state, ack_next;
    buf_state_t buf_state, buf_next;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              req;
    logic              accept;
    logic              wr_direct;
    logic              wr_post;
    logic              drain;

    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic [NB-1:0]     cpu_mask;
    logic [NB-1:0]     buf_mask_eff;

    logic              wa_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data;
    logic [NB-1:0]     wa_mask;

    logic [DATA_W-1:0] rd_word;
    logic              rd_live;
    logic              rd_hit;
    logic [DATA_W-1:0] merged;
    logic              unused_bits;

    assign idx      = adr_i[OFS+ADDR_W-1:OFS];
    assign in_range = int'(idx) < DEPTH;
    assign ack_o    = (ack_state == ACK);
    assign pend_o   = (buf_state == FULL);
    assign req      = cyc_i & stb_i & ~ack_o;

    // Writes are held off while the buffer is full; reads and out-of-range writes never stall.
    assign accept    = req & (~we_i | ~pend_o | ~in_range);
    assign wr_direct = req & we_i & ~pend_o & in_range & (idx != vga_addr);
    assign wr_post   = req & we_i & ~pend_o & in_range & (idx == vga_addr);
    assign drain     = pend_o & (buf_addr != vga_addr);

`ifdef VRAM_WB_DP_BYTE_SEL_EN
    logic [NB-1:0] buf_mask;

    assign cpu_mask     = sel_i;
    assign buf_mask_eff = buf_mask;

    always_ff @(posedge clk) begin
        if (wr_post) begin
            buf_mask <= sel_i;
        end
    end

    always_comb begin
        merged = rd_word;
        for (int b = 0; b < NB; b++) begin
            if (rd_hit && buf_mask[b]) begin
                merged[8*b +: 8] = buf_data[8*b +: 8];
            end
        end
    end

    assign unused_bits = ^adr_i;
`else
    assign cpu_mask     = '1;
    assign buf_mask_eff = '1;
    assign merged       = rd_hit ? buf_data : rd_word;
    assign unused_bits  = ^{adr_i, sel_i};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_state <= IDLE;
            buf_state <= EMPTY;
        end else begin
            ack_state <= ack_next;
            buf_state <= buf_next;
        end
    end

    always_comb begin
        ack_next = IDLE;
        buf_next = buf_state;
        if (ack_state == IDLE && accept) begin
            ack_next = ACK;
        end
        if (drain) begin
            buf_next = EMPTY;
        end else if (wr_post) begin
            buf_next = FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_post) begin
            buf_addr <= idx;
            buf_data <= dat_i;
        end
    end

    // A drain and a new CPU write are mutually exclusive (writes need an empty buffer).
    always_comb begin
        wa_en   = 1'b0;
        wa_addr = idx;
        wa_data = dat_i;
        wa_mask = cpu_mask;
        if (drain) begin
            wa_en   = 1'b1;
            wa_addr = buf_addr;
            wa_data = buf_data;
            wa_mask = buf_mask_eff;
        end else if (wr_direct) begin
            wa_en = 1'b1;
        end
    end

    // Port A: read-first, so a read racing a drain sees the old word and merges the buffer over it.
    always_ff @(posedge clk) begin
        if (wa_en && !rst) begin
            for (int b = 0; b < NB; b++) begin
                if (wa_mask[b]) begin
                    mem[wa_addr][8*b +: 8] <= wa_data[8*b +: 8];
                end
            end
        end
        rd_word <= mem[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_dout <= '0;
        end else begin
            vga_dout <= mem[vga_addr];
        end
    end

    // The buffer cannot change during the ack cycle, so only the hit flag is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_live <= 1'b0;
            rd_hit  <= 1'b0;
        end else if (accept) begin
            rd_live <= ~we_i & in_range;
            rd_hit  <= pend_o & (idx == buf_addr);
        end
    end

    assign dat_o = (ack_o && rd_live) ? merged : '0;

endmodule
